mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4:1 multiplexer datapath. Four requesters compete for one output lane. The block grants one requester at a time, drives the 2-bit select, and registers the selected input onto a single shared output with a valid flag. It sits in front of, and replaces manual `sel` driving of, the existing 4:1 mux stage.

---
 rtl/mux4_arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
// Holds the FSM state encoding, the datapath widths and a one-hot helper.
package mux4_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = {N_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr (mod 4)
// and returns the first index with its request bit set.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand_s;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        idx    = {SEL_W{1'b0}};
        found  = 1'b0;
        cand_s = {SEL_W{1'b0}};
        for (int k = N_REQ; k >= 1; k--) begin
            cand_s = ptr + SEL_W'(k);
            if (req[cand_s]) begin
                idx   = cand_s;
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux with a registered output lane.
// Optional per-requester hold limit is compiled in with MUX4_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [DW-1:0]    in1,
    input  logic [DW-1:0]    in2,
    input  logic [DW-1:0]    in3,
    input  logic [DW-1:0]    in4,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [DW-1:0]    ou1,
    output logic             ou_valid
);

    if (HOLD_MAX < 1 || HOLD_MAX > 16) begin : g_hold_max_range
        $error("mux4_rr_arbiter: HOLD_MAX must be within 1..16");
    end

    state_t           state_r, state_nx_s;
    logic [SEL_W-1:0] ptr_r, ptr_nx_s;
    logic [SEL_W-1:0] sel_r, sel_nx_s;
    logic [N_REQ-1:0] gnt_r, gnt_nx_s;
    logic             busy_r;
    logic [DW-1:0]    ou1_r, mux_s;
    logic             ou_valid_r;
    logic [SEL_W-1:0] pick_idx_s;
    logic             pick_found_s;
    logic             hold_hit_s;
    logic             release_s;
    logic             load_s;

    // ptr always equals the current grant while in GRANT, so one picker serves both cases.
    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;

    assign hold_hit_s = (cnt_r == HOLD_LAST);

    // Grant-length counter: restarts on every new grant and saturates instead of wrapping.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (load_s) begin
            cnt_nx_s = {CNT_W{1'b0}};
        end else if (state_r == GRANT && cnt_r != {CNT_W{1'b1}}) begin
            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Grant-length counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nx_s;
        end
    end
`else
    assign hold_hit_s = 1'b0;
`endif

    assign release_s = ~req[sel_r] | hold_hit_s;

    // Next-state, pointer and grant selection; a release with other requests hands over directly.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        sel_nx_s   = sel_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nx_s = GRANT;
                    ptr_nx_s   = pick_idx_s;
                    sel_nx_s   = pick_idx_s;
                    load_s     = 1'b1;
                end else begin
                    sel_nx_s   = {SEL_W{1'b0}};
                end
            end
            GRANT: begin
                if (release_s && pick_found_s) begin
                    ptr_nx_s   = pick_idx_s;
                    sel_nx_s   = pick_idx_s;
                    load_s     = 1'b1;
                end else if (release_s) begin
                    state_nx_s = IDLE;
                    sel_nx_s   = {SEL_W{1'b0}};
                end else begin
                    state_nx_s = GRANT;
                end
            end
            default: begin
                state_nx_s = IDLE;
                sel_nx_s   = {SEL_W{1'b0}};
            end
        endcase
        if (state_nx_s == GRANT) begin
            gnt_nx_s = idx_to_onehot(sel_nx_s);
        end else begin
            gnt_nx_s = {N_REQ{1'b0}};
        end
    end

    // 4:1 data select driven by the registered grant index.
    always_comb begin
        case (sel_r)
            2'd0:    mux_s = in1;
            2'd1:    mux_s = in2;
            2'd2:    mux_s = in3;
            2'd3:    mux_s = in4;
            default: mux_s = {DW{1'b0}};
        endcase
    end

    // Control and output registers; the data stage trails the select by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= 2'd3;
            sel_r      <= {SEL_W{1'b0}};
            gnt_r      <= {N_REQ{1'b0}};
            busy_r     <= 1'b0;
            ou1_r      <= {DW{1'b0}};
            ou_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ptr_r      <= ptr_nx_s;
            sel_r      <= sel_nx_s;
            gnt_r      <= gnt_nx_s;
            busy_r     <= (state_nx_s == GRANT);
            ou1_r      <= (state_r == GRANT) ? mux_s : {DW{1'b0}};
            ou_valid_r <= (state_r == GRANT);
        end
    end

    assign gnt      = gnt_r;
    assign sel      = sel_r;
    assign busy     = busy_r;
    assign ou1      = ou1_r;
    assign ou_valid = ou_valid_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter with a scoreboard queue and a
// decoupled monitor; expectations follow MUX4_ARB_HOLD_LIMIT_EN when defined.
module tb_mux4_rr_arbiter;

    localparam int DW       = 4;
    localparam int HOLD_MAX = 4;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] in1, in2, in3, in4;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic [DW-1:0] ou1;
    logic          ou_valid;

    typedef struct {
        logic [3:0]    gnt;
        logic [1:0]    sel;
        logic          busy;
        logic          ov;
        logic [DW-1:0] ou;
        int            id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors  = 0;
    int   checks  = 0;
    int   step_no = 0;
    logic [DW-1:0] dat [4] = '{4'h1, 4'h0, 4'hC, 4'hD};

    mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .ou1      (ou1),
        .ou_valid (ou_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                        input logic [1:0] es, input logic ev, input logic [DW-1:0] eo);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        e.gnt  = eg;
        e.sel  = es;
        e.busy = (eg != 4'b0000);
        e.ov   = ev;
        e.ou   = eo;
        e.id   = step_no;
        step_no++;
        sbq.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation after every edge.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if ({gnt, sel, busy, ou_valid, ou1} !== {mon_e.gnt, mon_e.sel, mon_e.busy, mon_e.ov, mon_e.ou}) begin
                errors++;
                $display("FAIL step%0d: got gnt=%b sel=%0d busy=%b ou_valid=%b ou1=%h, want gnt=%b sel=%0d busy=%b ou_valid=%b ou1=%h",
                         mon_e.id, gnt, sel, busy, ou_valid, ou1,
                         mon_e.gnt, mon_e.sel, mon_e.busy, mon_e.ov, mon_e.ou);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        in1 = 4'h1;
        in2 = 4'h0;
        in3 = 4'hC;
        in4 = 4'hD;

        // reset with all requests high
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'h0);
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'h0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        // single requester 2 for three cycles
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 4'h0);
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'hC);
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'hC);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'hC);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        // data routing: requesters 0 then 1, one grant cycle each
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, 4'h0);
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 4'h1);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'h0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        // mid-grant reset, then 0110 must pick requester 1 (pointer back at 3)
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, 4'h0);
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 4'h0);
        step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 4'h0);
        step(1'b0, 4'b0110, 4'b0010, 2'd1, 1'b0, 4'h0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'h0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        // rotation from pointer 1 and zero-bubble handover 3 -> 0
        step(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0, 4'h0);
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 4'hD);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'h1);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        // 0011 held ten cycles, then requester 0 drops
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, 4'h0);
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'h1);
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'h1);
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'h1);
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 4'h1);
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 4'h0);
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 4'h0);
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 4'h0);
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'h0);
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'h1);
`else
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, 4'h0);
        for (int i = 1; i < 10; i++) begin
            step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'h1);
        end
`endif
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 4'h1);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'h0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        // all four requesting continuously
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);
        for (int i = 0; i < 17; i++) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            step(1'b0, 4'b1111, 4'b0001 << ((i / 4) % 4), 2'((i / 4) % 4),
                 (i > 0), (i > 0) ? dat[((i - 1) / 4) % 4] : 4'h0);
`else
            step(1'b0, 4'b1111, 4'b0001, 2'd0, (i > 0), (i > 0) ? 4'h1 : 4'h0);
`endif
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'h1);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        // lone requester is re-granted across any hold-limit release
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 4'h0);
        for (int i = 1; i < 6; i++) begin
            step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'hC);
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'hC);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0);

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
